// File: rtl/key_evt_pkg.sv
// ============================================================================
// Module : key_evt_pkg
// Brief  : Shared constants and event-word helper for the key-event arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_evt_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int VALID_BIT = 31;
    localparam int OVF_BIT   = 8;
    localparam int EN_A      = 0;
    localparam int EN_B      = 1;
    localparam int IRQ_EN    = 2;

    localparam int         EVT_W    = 10;
    localparam logic [2:0] CTRL_RST = 3'b011;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic logic [EVT_W-1:0] make_evt(input src_e src, input logic mk,
                                                  input logic [7:0] code);
        return {src, mk, code};
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_evt_fifo.sv
// ============================================================================
// Module : key_evt_fifo
// Brief  : Power-of-two event FIFO, synchronous write, combinational head read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int EVT_W = 10,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [EVT_W-1:0] i_din,
    output logic [EVT_W-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [EVT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nios_system_key_event_arb.sv
// ============================================================================
// Module : nios_system_key_event_arb
// Brief  : Round-robin merge of two keypad event sources into a CPU-drained FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nios_system_key_event_arb
    import key_evt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        a_valid,
    input  logic        a_make,
    input  logic [7:0]  a_code,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic        b_make,
    input  logic [7:0]  b_code,
    output logic        b_ready
);

    logic [2:0]       r_ctrl;
    logic             r_ovf;
    logic             r_irq;
    src_e             r_rr_ptr;

    logic             w_rd;
    logic             w_wr;
    logic             w_cand_a;
    logic             w_cand_b;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [EVT_W-1:0] w_din;
    logic [EVT_W-1:0] w_dout;
    logic [CNT_W-1:0] w_count;
    logic             w_unused_wdata;

    assign w_rd = chipselect & ~read_n;
    assign w_wr = chipselect & ~write_n;
    assign w_unused_wdata = ^{writedata[31:9], writedata[7:3]};

    // Disabled sources are never candidates; they are always ready and drop events.
    assign w_cand_a  = r_ctrl[EN_A] & a_valid;
    assign w_cand_b  = r_ctrl[EN_B] & b_valid;
    assign w_grant_b = w_cand_b & (~w_cand_a | (r_rr_ptr == SRC_B));
    assign w_grant_a = w_cand_a & ~w_grant_b;
    assign w_push    = (w_grant_a | w_grant_b) & ~w_full;
    assign w_pop     = w_rd & (address == ADDR_DATA) & ~w_empty;

    assign a_ready = ~r_ctrl[EN_A] | (w_grant_a & ~w_full);
    assign b_ready = ~r_ctrl[EN_B] | (w_grant_b & ~w_full);
    assign w_din   = w_grant_b ? make_evt(SRC_B, b_make, b_code)
                               : make_evt(SRC_A, a_make, a_code);
    assign irq     = r_irq;

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .EVT_W (EVT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl   <= CTRL_RST;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_rr_ptr <= SRC_A;
        end else begin
            if (w_wr && (address == ADDR_CTRL)) begin
                r_ctrl <= writedata[2:0];
            end
            // A dropped event outranks a concurrent software clear.
            if (w_full && (w_cand_a || w_cand_b)) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (address == ADDR_STATUS) && writedata[OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
            if (w_push) begin
                r_rr_ptr <= w_grant_b ? SRC_A : SRC_B;
            end
            r_irq <= r_ctrl[IRQ_EN] & ~w_empty;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
                if (!w_empty) begin
                    readdata[VALID_BIT]   = 1'b1;
                    readdata[EVT_W-1:0]   = w_dout;
                end
            end
            ADDR_STATUS: begin
                readdata[OVF_BIT]     = r_ovf;
                readdata[CNT_W-1:0]   = w_count;
            end
            ADDR_CTRL: begin
                readdata[2:0] = r_ctrl;
            end
            default: readdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_nios_system_key_event_arb.sv
// ============================================================================
// Module : tb_nios_system_key_event_arb
// Brief  : Self-checking bench for the key-event arbiter with a queue-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nios_system_key_event_arb;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        a_valid, a_make, a_ready;
    logic [7:0]  a_code;
    logic        b_valid, b_make, b_ready;
    logic [7:0]  b_code;

    always #5 clk = ~clk;

    nios_system_key_event_arb #(.DEPTH(DEPTH), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .a_valid    (a_valid),
        .a_make     (a_make),
        .a_code     (a_code),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_make     (b_make),
        .b_code     (b_code),
        .b_ready    (b_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of event words plus software-visible state.
    logic [9:0]  mq[$];
    logic        m_ovf, m_irq, m_rr;
    logic [2:0]  m_ctrl;

    logic [31:0] s_rd;
    logic        s_ar, s_br, s_irq;

    typedef struct {
        logic        av; logic am; logic [7:0] ac;
        logic        bv; logic bm; logic [7:0] bc;
        int          op; logic [1:0] ad; logic [31:0] wd;
        logic [31:0] erd; logic ear; logic ebr;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_irq  = 1'b0;
        m_rr   = 1'b0;
        m_ctrl = 3'b011;
    endtask

    task automatic idle_inputs();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 2'd0; writedata = '0;
        a_valid = 1'b0; a_make = 1'b0; a_code = '0;
        b_valid = 1'b0; b_make = 1'b0; b_code = '0;
    endtask

    // One clock of stimulus; op: 0 idle, 1 read, 2 write.
    task automatic step(input logic av, input logic am, input logic [7:0] ac,
                        input logic bv, input logic bm, input logic [7:0] bc,
                        input int op, input logic [1:0] ad, input logic [31:0] wd);
        logic full, empty, ca, cb, gany, gsrc, ear, ebr;
        logic [31:0] erd;
        a_valid = av; a_make = am; a_code = ac;
        b_valid = bv; b_make = bm; b_code = bc;
        chipselect = (op != 0); read_n = (op != 1); write_n = (op != 2);
        address = ad; writedata = wd;
        #2;
        s_rd = readdata; s_ar = a_ready; s_br = b_ready; s_irq = irq;

        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        ca    = m_ctrl[0] & av;
        cb    = m_ctrl[1] & bv;
        gany  = ca | cb;
        gsrc  = (ca && cb) ? m_rr : cb;
        ear   = !m_ctrl[0] || (gany && !gsrc && !full);
        ebr   = !m_ctrl[1] || (gany && gsrc && !full);
        case (ad)
            2'd0:    erd = empty ? 32'h0 : {1'b1, 21'b0, mq[0]};
            2'd1:    erd = 32'(mq.size()) | (m_ovf ? 32'h100 : 32'h0);
            2'd2:    erd = {29'b0, m_ctrl};
            default: erd = 32'h0;
        endcase

        check("a_ready", 32'(s_ar), 32'(ear));
        check("b_ready", 32'(s_br), 32'(ebr));
        check("irq", 32'(s_irq), 32'(m_irq));
        if (op == 1) check("readdata", s_rd, erd);

        m_irq = m_ctrl[2] && !empty;
        if (op == 1 && ad == 2'd0 && !empty) void'(mq.pop_front());
        if (gany && !full) begin
            mq.push_back({gsrc, gsrc ? bm : am, gsrc ? bc : ac});
            m_rr = !gsrc;
        end
        if (full && gany) m_ovf = 1'b1;
        else if (op == 2 && ad == 2'd1 && wd[8]) m_ovf = 1'b0;
        if (op == 2 && ad == 2'd2) m_ctrl = wd[2:0];

        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    function automatic vec_t mk(input logic av, input logic am, input logic [7:0] ac,
                                input logic bv, input logic bm, input logic [7:0] bc,
                                input int op, input logic [1:0] ad, input logic [31:0] wd,
                                input logic [31:0] erd, input logic ear, input logic ebr);
        vec_t v;
        v.av = av; v.am = am; v.ac = ac; v.bv = bv; v.bm = bm; v.bc = bc;
        v.op = op; v.ad = ad; v.wd = wd; v.erd = erd; v.ear = ear; v.ebr = ebr;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0,0,8'h00, 0,0,8'h00, 1,2'd0,32'h0,         32'h0,        0,0);
        tbl[1]  = mk(0,0,8'h00, 0,0,8'h00, 1,2'd1,32'h0,         32'h0,        0,0);
        tbl[2]  = mk(0,0,8'h00, 0,0,8'h00, 1,2'd2,32'h0,         32'h3,        0,0);
        tbl[3]  = mk(0,0,8'h00, 0,0,8'h00, 1,2'd3,32'h0,         32'h0,        0,0);
        tbl[4]  = mk(1,1,8'h1C, 0,0,8'h00, 0,2'd0,32'h0,         32'h0,        1,0);
        tbl[5]  = mk(0,0,8'h00, 0,0,8'h00, 1,2'd0,32'h0,         32'h8000011C, 0,0);
        tbl[6]  = mk(0,0,8'h00, 0,0,8'h00, 1,2'd1,32'h0,         32'h0,        0,0);
        tbl[7]  = mk(1,1,8'h21, 1,0,8'h32, 0,2'd0,32'h0,         32'h0,        0,1);
        tbl[8]  = mk(1,1,8'h21, 1,0,8'h32, 0,2'd0,32'h0,         32'h0,        1,0);
        tbl[9]  = mk(0,0,8'h00, 0,0,8'h00, 1,2'd1,32'h0,         32'h2,        0,0);
        tbl[10] = mk(0,0,8'h00, 0,0,8'h00, 1,2'd0,32'h0,         32'h80000232, 0,0);
        tbl[11] = mk(0,0,8'h00, 0,0,8'h00, 1,2'd0,32'h0,         32'h80000121, 0,0);
        tbl[12] = mk(0,0,8'h00, 0,0,8'h00, 2,2'd3,32'hFFFFFFFF,  32'h0,        0,0);
        tbl[13] = mk(0,0,8'h00, 0,0,8'h00, 1,2'd3,32'h0,         32'h0,        0,0);
        tbl[14] = mk(0,0,8'h00, 0,0,8'h00, 2,2'd2,32'hFFFFFFF8,  32'h0,        0,0);
        tbl[15] = mk(1,1,8'h44, 1,1,8'h55, 2,2'd2,32'h3,         32'h0,        1,1);
        tbl[16] = mk(0,0,8'h00, 0,0,8'h00, 1,2'd2,32'h0,         32'h3,        0,0);

        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset irq", 32'(irq), 32'h0);
        check("reset a_ready", 32'(a_ready), 32'h0);
        check("reset b_ready", 32'(b_ready), 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].av, tbl[i].am, tbl[i].ac, tbl[i].bv, tbl[i].bm, tbl[i].bc,
                 tbl[i].op, tbl[i].ad, tbl[i].wd);
            check($sformatf("tbl%0d a_ready", i), 32'(s_ar), 32'(tbl[i].ear));
            check($sformatf("tbl%0d b_ready", i), 32'(s_br), 32'(tbl[i].ebr));
            if (tbl[i].op == 1) check($sformatf("tbl%0d readdata", i), s_rd, tbl[i].erd);
        end

        // Contention: last grant was A, so B leads and grants alternate.
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 8'(8'h50 + k), 1, 0, 8'(8'h60 + k), 0, 2'd0, 32'h0);
            check("alt b_ready", 32'(s_br), 32'((k % 2) == 0));
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd0, 32'h0);
            check("alt src bit", 32'(s_rd[9]), 32'((k % 2) == 0));
        end

        // Fill with B, then overflow while B keeps requesting.
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 0, 8'h0, 1, 1, 8'(8'h70 + k), 0, 2'd0, 32'h0);
            check("fill b_ready", 32'(s_br), 32'h1);
        end
        step(0, 0, 8'h0, 1, 1, 8'h7F, 0, 2'd0, 32'h0);
        check("full b_ready", 32'(s_br), 32'h0);
        step(0, 0, 8'h0, 1, 1, 8'h7F, 1, 2'd1, 32'h0);
        check("ovf status", s_rd, 32'h108);
        step(0, 0, 8'h0, 1, 1, 8'h7F, 2, 2'd1, 32'h100);
        step(0, 0, 8'h0, 1, 1, 8'h7F, 1, 2'd1, 32'h0);
        check("ovf set wins", s_rd, 32'h108);
        step(0, 0, 8'h0, 0, 0, 8'h0, 2, 2'd1, 32'h100);
        step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd1, 32'h0);
        check("ovf cleared", s_rd, 32'h008);

        // Pop down to 3, simultaneous push/pop, then refill and drain across the wrap.
        for (int k = 0; k < 5; k++) step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd0, 32'h0);
        step(1, 0, 8'h80, 0, 0, 8'h0, 1, 2'd0, 32'h0);
        check("push+pop old head", s_rd, 32'h80000375);
        step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd1, 32'h0);
        check("push+pop count", s_rd, 32'h3);
        for (int k = 0; k < 5; k++) step(1, k[0], 8'(8'h90 + k), 0, 0, 8'h0, 0, 2'd0, 32'h0);
        for (int k = 0; k < DEPTH; k++) step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd0, 32'h0);
        step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd1, 32'h0);
        check("drained status", s_rd, 32'h0);

        // Sources disabled: accepted and discarded; then irq follows occupancy.
        step(0, 0, 8'h0, 0, 0, 8'h0, 2, 2'd2, 32'h4);
        step(1, 1, 8'hAA, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        check("disabled a_ready", 32'(s_ar), 32'h1);
        step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd1, 32'h0);
        check("disabled count", s_rd, 32'h0);
        step(0, 0, 8'h0, 0, 0, 8'h0, 2, 2'd2, 32'h5);
        step(1, 1, 8'hA5, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        step(0, 0, 8'h0, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd0, 32'h0);
        check("irq after push", 32'(s_irq), 32'h1);
        check("irq pop data", s_rd, 32'h800001A5);
        step(0, 0, 8'h0, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        step(0, 0, 8'h0, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        check("irq after pop", 32'(s_irq), 32'h0);

        // Asynchronous reset with events queued.
        step(1, 1, 8'hB1, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        step(1, 1, 8'hB2, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        step(0, 0, 8'h0, 0, 0, 8'h0, 0, 2'd0, 32'h0);
        check("pre-reset irq", 32'(s_irq), 32'h1);
        chipselect = 1'b1; read_n = 1'b0; address = 2'd1;
        #1;
        check("pre-reset status", readdata, 32'h2);
        reset = 1'b1;
        #1;
        check("async reset irq", 32'(irq), 32'h0);
        check("async reset status", readdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        step(0, 0, 8'h0, 0, 0, 8'h0, 1, 2'd2, 32'h0);
        check("post-reset ctrl", s_rd, 32'h3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int op;
            logic [1:0] ad;
            logic [31:0] wd;
            r  = $urandom_range(0, 99);
            wd = $urandom;
            op = 0;
            ad = 2'd0;
            if (r < 25) begin
                op = 1; ad = 2'd0;
            end else if (r < 35) begin
                op = 1; ad = 2'($urandom_range(1, 3));
            end else if (r < 38) begin
                op = 2; ad = 2'd2;
            end else if (r < 43) begin
                op = 2; ad = 2'd1;
            end else if (r < 45) begin
                op = 2; ad = 2'd3;
            end
            step($urandom_range(0, 99) < 55, 1'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < 55, 1'($urandom), 8'($urandom),
                 op, ad, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
